// File: rtl/imm_gen_pkg.sv
// Shared opcode constants and immediate-class encoding for the immediate
// generator pipeline.
package imm_gen_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'h03;
   localparam logic [6:0] OPC_OP_IMM = 7'h13;
   localparam logic [6:0] OPC_AUIPC  = 7'h17;
   localparam logic [6:0] OPC_STORE  = 7'h23;
   localparam logic [6:0] OPC_LUI    = 7'h37;
   localparam logic [6:0] OPC_BRANCH = 7'h63;
   localparam logic [6:0] OPC_JALR   = 7'h67;
   localparam logic [6:0] OPC_JAL    = 7'h6F;
   localparam logic [6:0] OPC_SYSTEM = 7'h73;

   typedef enum logic [2:0] {
      IMM_I     = 3'd0,
      IMM_SHAMT = 3'd1,
      IMM_S     = 3'd2,
      IMM_B     = 3'd3,
      IMM_U     = 3'd4,
      IMM_J     = 3'd5,
      IMM_Z     = 3'd6,
      IMM_NONE  = 3'd7
   } imm_type_e;

   // Shift-immediate forms of OP-IMM (slli / srli / srai) carry a shamt, not an imm12.
   function automatic logic is_shift_funct3(input logic [2:0] funct3);
      return (funct3 == 3'b001) || (funct3 == 3'b101);
   endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extraction: raw instruction word to sign/zero
// extended immediate, its class, and the illegal (non-32-bit encoding) flag.
module imm_decode
   import imm_gen_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     inst,
   output logic [XLEN-1:0] imm,
   output imm_type_e       imm_type,
   output logic            illegal
);

   logic [6:0] opcode_s;
   logic [2:0] funct3_s;
   logic       illegal_s;

   assign opcode_s  = inst[6:0];
   assign funct3_s  = inst[14:12];
   assign illegal_s = (inst[1:0] != 2'b11);
   assign illegal   = illegal_s;

   // Immediate selection by opcode; illegal words and unknown opcodes yield zero / NONE.
   always_comb begin
      imm      = {XLEN{1'b0}};
      imm_type = IMM_NONE;
      if (illegal_s) begin
         imm      = {XLEN{1'b0}};
         imm_type = IMM_NONE;
      end else begin
         case (opcode_s)
            OPC_LOAD, OPC_JALR: begin
               imm      = XLEN'($signed(inst[31:20]));
               imm_type = IMM_I;
            end
            OPC_OP_IMM: begin
               if (is_shift_funct3(funct3_s)) begin
                  // RV64 shamt is 6 bits wide; funct7 bits never leak into the value
                  imm      = (XLEN == 64) ? XLEN'(inst[25:20]) : XLEN'(inst[24:20]);
                  imm_type = IMM_SHAMT;
               end else begin
                  imm      = XLEN'($signed(inst[31:20]));
                  imm_type = IMM_I;
               end
            end
            OPC_STORE: begin
               imm      = XLEN'($signed({inst[31:25], inst[11:7]}));
               imm_type = IMM_S;
            end
            OPC_BRANCH: begin
               imm      = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
               imm_type = IMM_B;
            end
            OPC_AUIPC, OPC_LUI: begin
               imm      = XLEN'($signed({inst[31:12], 12'h000}));
               imm_type = IMM_U;
            end
            OPC_JAL: begin
               imm      = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
               imm_type = IMM_J;
            end
            OPC_SYSTEM: begin
               imm      = XLEN'(inst[19:15]);
               imm_type = IMM_Z;
            end
            default: begin
               imm      = {XLEN{1'b0}};
               imm_type = IMM_NONE;
            end
         endcase
      end
   end

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator with a small FIFO output buffer: instructions are
// decoded on entry and delivered in order with a valid/ready handshake.
module imm_gen_pipe
   import imm_gen_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 32,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_inst,
   input  logic [TAG_W-1:0] in_tag,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [2:0]       out_type,
   output logic             out_illegal,
   output logic [TAG_W-1:0] out_tag,
   output logic [15:0]      illegal_cnt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   logic [XLEN-1:0]  dec_imm_s;
   imm_type_e        dec_type_s;
   logic             dec_illegal_s;

   logic [XLEN-1:0]  imm_mem_r  [DEPTH];
   imm_type_e        type_mem_r [DEPTH];
   logic             ill_mem_r  [DEPTH];
   logic [TAG_W-1:0] tag_mem_r  [DEPTH];

   logic [CNT_W-1:0] count_r;
   logic [CNT_W-1:0] count_nxt_s;
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [15:0]      illegal_cnt_r;

   logic in_ready_s;
   logic out_valid_s;
   logic enq_s;
   logic deq_s;

   imm_decode #(.XLEN(XLEN)) u_decode (
      .inst     (in_inst),
      .imm      (dec_imm_s),
      .imm_type (dec_type_s),
      .illegal  (dec_illegal_s)
   );

   // Full-ness alone gates acceptance, so a dequeue cannot make room in the same cycle.
   assign in_ready_s  = (count_r != CNT_FULL);
   assign out_valid_s = (count_r != CNT_ZERO);
   assign enq_s       = in_valid && in_ready_s && !flush;
   assign deq_s       = out_valid_s && out_ready && !flush;

   // Occupancy update from the enqueue/dequeue pair.
   always_comb begin
      count_nxt_s = count_r;
      case ({enq_s, deq_s})
         2'b10:   count_nxt_s = count_r + CNT_ONE;
         2'b01:   count_nxt_s = count_r - CNT_ONE;
         default: count_nxt_s = count_r;
      endcase
   end

   // Buffer control state; flush empties the buffer and outranks both handshakes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_r  <= CNT_ZERO;
         wr_ptr_r <= PTR_ZERO;
         rd_ptr_r <= PTR_ZERO;
      end else if (flush) begin
         count_r  <= CNT_ZERO;
         wr_ptr_r <= PTR_ZERO;
         rd_ptr_r <= PTR_ZERO;
      end else begin
         count_r <= count_nxt_s;
         if (enq_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (deq_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
      end
   end

   // Payload storage; never reset since occupancy alone defines validity.
   always_ff @(posedge clk) begin
      if (enq_s) begin
         imm_mem_r[wr_ptr_r]  <= dec_imm_s;
         type_mem_r[wr_ptr_r] <= dec_type_s;
         ill_mem_r[wr_ptr_r]  <= dec_illegal_s;
         tag_mem_r[wr_ptr_r]  <= in_tag;
      end
   end

   // Saturating count of illegal entries actually handed to the consumer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         illegal_cnt_r <= 16'h0000;
      end else if (deq_s && ill_mem_r[rd_ptr_r] && (illegal_cnt_r != 16'hFFFF)) begin
         illegal_cnt_r <= illegal_cnt_r + 16'h0001;
      end else begin
         illegal_cnt_r <= illegal_cnt_r;
      end
   end

   // Head-of-buffer presentation; idle outputs are forced to a benign NONE entry.
   always_comb begin
      out_imm     = {XLEN{1'b0}};
      out_type    = IMM_NONE;
      out_illegal = 1'b0;
      out_tag     = {TAG_W{1'b0}};
      if (out_valid_s) begin
         out_imm     = imm_mem_r[rd_ptr_r];
         out_type    = type_mem_r[rd_ptr_r];
         out_illegal = ill_mem_r[rd_ptr_r];
         out_tag     = tag_mem_r[rd_ptr_r];
      end else begin
         out_imm     = {XLEN{1'b0}};
         out_type    = IMM_NONE;
         out_illegal = 1'b0;
         out_tag     = {TAG_W{1'b0}};
      end
   end

   assign in_ready    = in_ready_s;
   assign out_valid   = out_valid_s;
   assign illegal_cnt = illegal_cnt_r;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share
// one stimulus stream and are compared against a queue-based reference model.
module tb_imm_gen_pipe;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_inst = 32'h0;
   logic [31:0] in_tag = 32'h0;
   logic        flush = 1'b0;
   logic        out_ready = 1'b0;

   logic        d32_in_ready, d32_out_valid, d32_out_illegal;
   logic [31:0] d32_out_imm, d32_out_tag;
   logic [2:0]  d32_out_type;
   logic [15:0] d32_illegal_cnt;

   logic        d64_in_ready, d64_out_valid, d64_out_illegal;
   logic [63:0] d64_out_imm;
   logic [31:0] d64_out_tag;
   logic [2:0]  d64_out_type;
   logic [15:0] d64_illegal_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   imm_gen_pipe #(.XLEN(32), .TAG_W(32), .DEPTH(DEPTH)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d32_in_ready),
      .in_inst(in_inst), .in_tag(in_tag), .flush(flush), .out_valid(d32_out_valid),
      .out_ready(out_ready), .out_imm(d32_out_imm), .out_type(d32_out_type),
      .out_illegal(d32_out_illegal), .out_tag(d32_out_tag), .illegal_cnt(d32_illegal_cnt)
   );

   imm_gen_pipe #(.XLEN(64), .TAG_W(32), .DEPTH(DEPTH)) u_dut64 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d64_in_ready),
      .in_inst(in_inst), .in_tag(in_tag), .flush(flush), .out_valid(d64_out_valid),
      .out_ready(out_ready), .out_imm(d64_out_imm), .out_type(d64_out_type),
      .out_illegal(d64_out_illegal), .out_tag(d64_out_tag), .illegal_cnt(d64_illegal_cnt)
   );

   typedef struct {
      logic [31:0] inst;
      logic [31:0] tag;
   } ent_t;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] imm32;
      logic [63:0] imm64;
      logic [2:0]  typ;
      logic        ill;
   } vec_t;

   ent_t q[$];
   int   mcnt = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference decode from the immediate-format rules, using plain integer arithmetic.
   function automatic void ref_dec(input logic [31:0] i, input int xlen,
                                   output logic [63:0] imm, output logic [2:0] typ);
      longint u;
      longint v;
      int     f3;
      u  = longint'({32'h0, i});
      f3 = int'((u >> 12) & 7);
      v  = 0;
      typ = 3'd7;
      if (i[1:0] == 2'b11) begin
         case (i[6:0])
            7'h03, 7'h67, 7'h13: begin
               if (i[6:0] == 7'h13 && (f3 == 1 || f3 == 5)) begin
                  v = (xlen == 64) ? ((u >> 20) & 63) : ((u >> 20) & 31);
                  typ = 3'd1;
               end else begin
                  v = (u >> 20) & 4095;
                  if (v >= 2048) v = v - 4096;
                  typ = 3'd0;
               end
            end
            7'h23: begin
               v = (((u >> 25) & 127) * 32) + ((u >> 7) & 31);
               if (v >= 2048) v = v - 4096;
               typ = 3'd2;
            end
            7'h63: begin
               v = ((u >> 31) & 1) * 4096 + ((u >> 7) & 1) * 2048
                 + ((u >> 25) & 63) * 32 + ((u >> 8) & 15) * 2;
               if (v >= 4096) v = v - 8192;
               typ = 3'd3;
            end
            7'h17, 7'h37: begin
               v = (u >> 12) * 4096;
               if (v >= 64'sh8000_0000) v = v - 64'sh1_0000_0000;
               typ = 3'd4;
            end
            7'h6F: begin
               v = ((u >> 31) & 1) * 1048576 + ((u >> 12) & 255) * 4096
                 + ((u >> 20) & 1) * 2048 + ((u >> 21) & 1023) * 2;
               if (v >= 1048576) v = v - 2097152;
               typ = 3'd5;
            end
            7'h73: begin
               v = (u >> 15) & 31;
               typ = 3'd6;
            end
            default: begin
               v = 0;
               typ = 3'd7;
            end
         endcase
      end
      imm = (xlen == 64) ? 64'(v) : {32'h0, 32'(v)};
   endfunction

   task automatic check_model();
      logic [63:0] e32, e64;
      logic [2:0]  t32, t64;
      logic        ill;
      chk("in_ready32", {63'h0, d32_in_ready}, {63'h0, (q.size() != DEPTH)});
      chk("in_ready64", {63'h0, d64_in_ready}, {63'h0, (q.size() != DEPTH)});
      chk("out_valid32", {63'h0, d32_out_valid}, {63'h0, (q.size() != 0)});
      chk("out_valid64", {63'h0, d64_out_valid}, {63'h0, (q.size() != 0)});
      if (q.size() != 0) begin
         ref_dec(q[0].inst, 32, e32, t32);
         ref_dec(q[0].inst, 64, e64, t64);
         ill = (q[0].inst[1:0] != 2'b11);
         chk("imm32", {32'h0, d32_out_imm}, e32);
         chk("imm64", d64_out_imm, e64);
         chk("type32", {61'h0, d32_out_type}, {61'h0, t32});
         chk("type64", {61'h0, d64_out_type}, {61'h0, t64});
         chk("illegal32", {63'h0, d32_out_illegal}, {63'h0, ill});
         chk("illegal64", {63'h0, d64_out_illegal}, {63'h0, ill});
         chk("tag32", {32'h0, d32_out_tag}, {32'h0, q[0].tag});
         chk("tag64", {32'h0, d64_out_tag}, {32'h0, q[0].tag});
      end
      chk("illcnt32", {48'h0, d32_illegal_cnt}, 64'(mcnt));
      chk("illcnt64", {48'h0, d64_illegal_cnt}, 64'(mcnt));
   endtask

   // One cycle: check outputs at the falling edge, drive new inputs, advance the model.
   task automatic tick(input logic v, input logic [31:0] inst, input logic [31:0] tag,
                       input logic ordy, input logic fl);
      int   pre;
      ent_t e;
      @(negedge clk);
      check_model();
      in_valid  = v;
      in_inst   = inst;
      in_tag    = tag;
      out_ready = ordy;
      flush     = fl;
      pre = q.size();
      if (fl) begin
         q.delete();
      end else begin
         if (pre != 0 && ordy) begin
            e = q.pop_front();
            if (e.inst[1:0] != 2'b11 && mcnt < 65535) mcnt++;
         end
         if (v && pre < DEPTH) q.push_back('{inst, tag});
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      q.delete();
      mcnt = 0;
      @(negedge clk);
      chk("rst_out_valid32", {63'h0, d32_out_valid}, 64'h0);
      chk("rst_out_valid64", {63'h0, d64_out_valid}, 64'h0);
      chk("rst_in_ready32", {63'h0, d32_in_ready}, 64'h1);
      chk("rst_in_ready64", {63'h0, d64_in_ready}, 64'h1);
      chk("rst_illcnt32", {48'h0, d32_illegal_cnt}, 64'h0);
      chk("rst_illcnt64", {48'h0, d64_illegal_cnt}, 64'h0);
      rst_n = 1'b1;
   endtask

   function automatic logic [31:0] rnd_inst();
      logic [6:0]  ops [0:10] = '{7'h03, 7'h13, 7'h13, 7'h67, 7'h23, 7'h63,
                                  7'h17, 7'h37, 7'h6F, 7'h73, 7'h33};
      logic [31:0] r;
      r = $urandom;
      r[6:0] = ops[$urandom_range(0, 10)];
      if ($urandom_range(0, 7) == 0) r[1:0] = 2'($urandom_range(0, 2));
      return r;
   endfunction

   vec_t vecs [14];

   initial begin
      vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 3'd0, 1'b0};
      vecs[1]  = '{32'h4030D093, 32'h00000003, 64'h00000000_00000003, 3'd1, 1'b0};
      vecs[2]  = '{32'hFE000EE3, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 3'd3, 1'b0};
      vecs[3]  = '{32'h800000B7, 32'h80000000, 64'hFFFFFFFF_80000000, 3'd4, 1'b0};
      vecs[4]  = '{32'hFE112E23, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 3'd2, 1'b0};
      vecs[5]  = '{32'hFF9FF06F, 32'hFFFFFFF8, 64'hFFFFFFFF_FFFFFFF8, 3'd5, 1'b0};
      vecs[6]  = '{32'h0002D073, 32'h00000005, 64'h00000000_00000005, 3'd6, 1'b0};
      vecs[7]  = '{32'h002081B3, 32'h00000000, 64'h00000000_00000000, 3'd7, 1'b0};
      vecs[8]  = '{32'h03F09093, 32'h0000001F, 64'h00000000_0000003F, 3'd1, 1'b0};
      vecs[9]  = '{32'h7FF02083, 32'h000007FF, 64'h00000000_000007FF, 3'd0, 1'b0};
      vecs[10] = '{32'h00000000, 32'h00000000, 64'h00000000_00000000, 3'd7, 1'b1};
      vecs[11] = '{32'h00001117, 32'h00001000, 64'h00000000_00001000, 3'd4, 1'b0};
      vecs[12] = '{32'hFFF00092, 32'h00000000, 64'h00000000_00000000, 3'd7, 1'b1};
      vecs[13] = '{32'hFFC08067, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 3'd0, 1'b0};

      do_reset();

      // Table vectors: one instruction at a time, visible one cycle after acceptance.
      for (int k = 0; k < 14; k++) begin
         tick(1'b1, vecs[k].inst, 32'(k + 100), 1'b1, 1'b0);
         tick(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
         chk("vec_valid", {62'h0, d32_out_valid, d64_out_valid}, 64'h3);
         chk("vec_imm32", {32'h0, d32_out_imm}, {32'h0, vecs[k].imm32});
         chk("vec_imm64", d64_out_imm, vecs[k].imm64);
         chk("vec_type", {58'h0, d32_out_type, d64_out_type}, {58'h0, vecs[k].typ, vecs[k].typ});
         chk("vec_ill", {62'h0, d32_out_illegal, d64_out_illegal}, {62'h0, vecs[k].ill, vecs[k].ill});
      end

      // Backpressure: two accepted, third held off until space frees up.
      do_reset();
      tick(1'b1, 32'hFFF00093, 32'd1, 1'b0, 1'b0);
      tick(1'b1, 32'h4030D093, 32'd2, 1'b0, 1'b0);
      tick(1'b1, 32'hFE000EE3, 32'd3, 1'b0, 1'b0);
      chk("bp_full_ready", {62'h0, d32_in_ready, d64_in_ready}, 64'h0);
      tick(1'b1, 32'hFE000EE3, 32'd3, 1'b1, 1'b0);
      chk("bp_head_a", {32'h0, d32_out_tag}, 64'd1);
      chk("bp_still_full", {63'h0, d32_in_ready}, 64'h0);
      tick(1'b1, 32'hFE000EE3, 32'd3, 1'b1, 1'b0);
      chk("bp_head_b", {32'h0, d32_out_tag}, 64'd2);
      tick(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("bp_head_c", {32'h0, d64_out_tag}, 64'd3);
      tick(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("bp_drained", {62'h0, d32_out_valid, d64_out_valid}, 64'h0);

      // Flush with a full buffer, then with one entry and an acceptable input.
      do_reset();
      tick(1'b1, 32'h00000013, 32'd11, 1'b0, 1'b0);
      tick(1'b1, 32'h00100093, 32'd12, 1'b0, 1'b0);
      tick(1'b1, 32'h00200093, 32'd13, 1'b0, 1'b1);
      tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      chk("flush_empty", {62'h0, d32_out_valid, d64_out_valid}, 64'h0);
      chk("flush_ready", {62'h0, d32_in_ready, d64_in_ready}, 64'h3);
      tick(1'b1, 32'h00300093, 32'd14, 1'b0, 1'b0);
      tick(1'b1, 32'h00400093, 32'd15, 1'b0, 1'b1);
      tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      chk("flush_drop_in", {62'h0, d32_out_valid, d64_out_valid}, 64'h0);
      tick(1'b1, 32'h00000000, 32'd16, 1'b1, 1'b0);
      tick(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("zero_illegal", {62'h0, d32_out_illegal, d64_out_illegal}, 64'h3);
      tick(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("illcnt_one", {48'h0, d32_illegal_cnt}, 64'd1);

      // Reset with two entries buffered drops them and clears the counter.
      tick(1'b1, 32'h00000001, 32'd21, 1'b0, 1'b0);
      tick(1'b1, 32'h00500093, 32'd22, 1'b0, 1'b0);
      tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      chk("pre_rst_full", {62'h0, d32_in_ready, d64_in_ready}, 64'h0);
      do_reset();

      // Randomized traffic with sporadic flushes and mid-stream resets.
      for (int n = 0; n < 3000; n++) begin
         if (n % 750 == 749) begin
            do_reset();
         end else begin
            tick($urandom_range(0, 3) != 0, rnd_inst(), $urandom,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
         end
      end

      // Counter saturation: stream illegal words past 0xFFFF deliveries.
      do_reset();
      for (int n = 0; n < 65540; n++) begin
         tick(1'b1, 32'h00000000, 32'(n), 1'b1, 1'b0);
      end
      tick(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      tick(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      tick(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("sat32", {48'h0, d32_illegal_cnt}, 64'hFFFF);
      chk("sat64", {48'h0, d64_illegal_cnt}, 64'hFFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter XLEN, default 32: datapath width; SHALL be 32 or 64.
REQ-002 Parameter TAG_W, default 32: width of sideband tag (PC) carried with each instruction.
REQ-003 Parameter DEPTH, default 2: output buffer entries; SHALL be power of two, at least 2.
REQ-004 clk  in  1  single clock; all state SHALL update on rising edge.
REQ-005 rst_n  in  1  reset; SHALL be synchronous and active-low.
REQ-006 in_valid  in  1  instruction offered.
REQ-007 in_ready  out  1  buffer can accept.
REQ-008 in_inst  in  32  raw instruction word.
REQ-009 in_tag  in  TAG_W  sideband, passed through unmodified.
REQ-010 flush  in  1  discard all buffered and incoming entries.
REQ-011 out_valid  out  1  head entry valid.
REQ-012 out_ready  in  1  consumer accepts head.
REQ-013 out_imm  out  XLEN  decoded immediate.
REQ-014 out_type  out  3  immediate class (I, SHAMT, S, B, U, J, Z, NONE).
REQ-015 out_illegal  out  1  inst[1:0] != 2'b11.
REQ-016 out_tag  out  TAG_W  tag of head entry.
REQ-017 illegal_cnt  out  16  saturating count of illegal entries delivered.

Function
REQ-018 Accept on in_valid and in_ready at a rising edge; deliver on out_valid and out_ready.
REQ-019 Decode SHALL occur before buffering; an accepted entry SHALL be visible on outputs in the cycle after acceptance when the buffer was empty (1-cycle latency).
REQ-020 in_ready SHALL equal (count != DEPTH), independent of out_ready; no enqueue when full, even if dequeuing that cycle.
REQ-021 Entries SHALL leave in acceptance order; outputs SHALL hold stable while out_valid and not out_ready.
REQ-022 Simultaneous enqueue and dequeue with 0 < count < DEPTH SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-023 I-type (opcodes 0x03, 0x13, 0x67): inst[31:20] sign-extended to XLEN.
REQ-024 SHAMT (opcode 0x13, funct3 001/101): inst[24:20] (XLEN=32) or inst[25:20] (XLEN=64), zero-extended; funct7 bits excluded.
REQ-025 S (0x23): {inst[31:25], inst[11:7]} sign-extended.
REQ-026 B (0x63): {inst[31], inst[7], inst[30:25], inst[11:8], 0} sign-extended.
REQ-027 U (0x17, 0x37): {inst[31:12], 12'b0} sign-extended to XLEN.
REQ-028 J (0x6F): {inst[31], inst[19:12], inst[20], inst[30:21], 0} sign-extended.
REQ-029 Z (0x73): inst[19:15] zero-extended.
REQ-030 All other opcodes, and any illegal entry: out_imm 0, out_type NONE.
REQ-031 illegal_cnt SHALL increment on each delivered entry with out_illegal=1, saturating at 0xFFFF; flush SHALL NOT clear it.
REQ-032 flush=1 at an edge SHALL empty the buffer and discard any concurrent input; flush dominates enqueue and dequeue.

Reset
REQ-033 While rst_n=0 at an edge: count, pointers, illegal_cnt SHALL become 0; out_valid 0; in_ready 1 from the following cycle.
REQ-034 Reset mid-stream SHALL drop all entries with no partial delivery; buffer payload storage need not be reset.

Structure
REQ-035 Package imm_gen_pkg SHALL hold opcode constants and the 3-bit imm_type encoding.
REQ-036 Combinational decode SHALL be sub-module imm_decode (inst -> imm, type, illegal, XLEN parameter); buffer and counter live in imm_gen_pipe.

Verification
REQ-037 XLEN=32, 0xFFF00093 (addi -1), out_ready=1 -> next cycle out_imm 0xFFFFFFFF, type I.
REQ-038 0x4030D093 (srai x1,x1,3) -> out_imm 0x00000003, type SHAMT; 0xFE000EE3 (beq -4) -> 0xFFFFFFFC, type B.
REQ-039 XLEN=64, 0x800000B7 (lui) -> out_imm 0xFFFFFFFF80000000, type U.
REQ-040 out_ready=0, offer 3 instructions -> in_ready low after 2 accepted; release -> delivered in order, third accepted afterwards.
REQ-041 Two entries buffered, flush=1 with in_valid=1 -> next cycle out_valid=0, count 0, new input lost; 0x00000000 delivered -> out_illegal=1, illegal_cnt +1, saturates at 0xFFFF.
REQ-042 rst_n=0 with 2 entries buffered -> next cycle out_valid=0, illegal_cnt 0, in_ready 1.
